// File: rtl/handshake_pkg.sv
// Shared types and helpers for the handshake burst constant block.
package handshake_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_burst_seq.sv
// Beat sequencer: tracks the position within a burst and accumulates the
// arithmetic sequence VALUE, VALUE+STRIDE, ... without a multiplier.
module handshake_burst_seq
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VALUE      = 1,
    parameter int STRIDE     = 0,
    parameter int COUNT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  last
);

    localparam int IDX_W = ctr_width(COUNT);
    localparam logic [DATA_WIDTH-1:0] FIRST_VALUE = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP_VALUE  = DATA_WIDTH'(STRIDE);

    logic [IDX_W-1:0]      idx_reg;
    logic [DATA_WIDTH-1:0] value_reg;
    logic                  last_reg;

    // Load wins over step: a new burst starting on the last beat restarts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg   <= '0;
            value_reg <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            idx_reg   <= '0;
            value_reg <= FIRST_VALUE;
            last_reg  <= (COUNT == 1);
        end else if (step) begin
            idx_reg   <= idx_reg + IDX_W'(1);
            value_reg <= value_reg + STEP_VALUE;
            last_reg  <= (int'(idx_reg) + 1 == COUNT - 1);
        end
    end

    assign value = value_reg;
    assign last  = last_reg;

endmodule

// File: rtl/handshake_constant_burst.sv
// Each accepted ctrl token produces a registered burst of COUNT beats on outs;
// the only combinational path is outs_ready to ctrl_ready on the last beat.
module handshake_constant_burst
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VALUE      = 1,
    parameter int STRIDE     = 0,
    parameter int COUNT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    if (COUNT < 1) begin : g_count_check
        $fatal(1, "handshake_constant_burst: COUNT must be >= 1");
    end

    state_t state_reg, state_next;
    logic   fire_out;
    logic   accept;
    logic   step;
    logic   seq_last;

    assign outs_valid = (state_reg == EMIT);
    assign fire_out   = outs_valid && outs_ready;
    assign outs_last  = seq_last;

    always_comb begin
        state_next = state_reg;
        ctrl_ready = !rst && ((state_reg == IDLE) || (fire_out && seq_last));
        accept     = ctrl_valid && ctrl_ready;
        step       = fire_out && !seq_last;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = EMIT;
            end
            EMIT: begin
                // Back-to-back tokens keep us in EMIT with no bubble.
                if (fire_out && seq_last) state_next = accept ? EMIT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    handshake_burst_seq #(
        .DATA_WIDTH(DATA_WIDTH),
        .VALUE     (VALUE),
        .STRIDE    (STRIDE),
        .COUNT     (COUNT)
    ) u_seq (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (step),
        .value(outs),
        .last (seq_last)
    );

endmodule
